icache_refill_ctrl_module: RTL and testbench

//  Sequential front end between IFU and the ITLB/ICACHE arrays. Replaces the single-cycle glue with an FSM.
//  - One outstanding fetch; its lifetime is tracked through ITLB miss, line miss, memory refill and response.
//  - Flushes are handled safely while memory or MMU traffic is in flight.
//  - Invalidates are snooped against the line being refilled.

---
 rtl/icache_refill_ctrl_module_pkg.sv | 39 +++
 rtl/icache_refill_ctrl_module_if.sv | 73 +++++++
 rtl/gnrl_dffr.sv | 16 +
 rtl/icache_refill_ctrl_module_fsm.sv | 88 ++++++++
 rtl/icache_refill_ctrl_module.sv | 131 +++++++++++++
 tb/tb_icache_refill_ctrl_module.sv | 354 +++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/icache_refill_ctrl_module_pkg.sv
// Shared definitions for the instruction-cache refill controller: default geometry,
// derived address-field widths and the FSM state encoding.
package icache_refill_ctrl_module_pkg;

    localparam int PC_W_DEF   = 39;
    localparam int PA_W_DEF   = 34;
    localparam int LINE_W_DEF = 512;
    localparam int SETS_DEF   = 256;
    localparam int ID_W_DEF   = 2;
    localparam int EXCP_W_DEF = 3;

    localparam int PAGE_OFS_W = 12;
    localparam int EXCP_NONE  = 0;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_MMU_REQ   = 4'd1,
        ST_MMU_WAIT  = 4'd2,
        ST_PROBE     = 4'd3,
        ST_MEM_REQ   = 4'd4,
        ST_MEM_WAIT  = 4'd5,
        ST_RESP      = 4'd6,
        ST_DRAIN_MMU = 4'd7,
        ST_DRAIN_MEM = 4'd8
    } state_e;

    function automatic int ofs_w(input int line_w);
        return $clog2(line_w / 8);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int pa_w, input int line_w, input int sets);
        return pa_w - idx_w(sets) - ofs_w(line_w);
    endfunction

endpackage

// File: rtl/icache_refill_ctrl_module_if.sv
// Bundle of every IFU, ITLB, MMU, icache-array, memory and response signal of the controller.
// The master modport is the controller side; the slave modport is its environment.
interface icache_refill_ctrl_module_if
    import icache_refill_ctrl_module_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int PA_W   = PA_W_DEF,
    parameter int LINE_W = LINE_W_DEF,
    parameter int SETS   = SETS_DEF,
    parameter int ID_W   = ID_W_DEF,
    parameter int EXCP_W = EXCP_W_DEF
) ();
    localparam int IDX_W = idx_w(SETS);
    localparam int TAG_W = tag_w(PA_W, LINE_W, SETS);
    localparam int PPN_W = PA_W - PAGE_OFS_W;

    logic              i_flush;
    logic              i_req_vld;
    logic              o_req_rdy;
    logic [PC_W-1:0]   i_req_pc;
    logic [ID_W-1:0]   i_req_id;
    logic              o_itlb_req;
    logic [PC_W-1:0]   o_itlb_vaddr;
    logic              i_itlb_hit;
    logic [PPN_W-1:0]  i_itlb_ppn;
    logic              o_mmu_vld;
    logic              i_mmu_rdy;
    logic [PC_W-1:0]   o_mmu_vaddr;
    logic              i_mmu_rsp_vld;
    logic [PA_W-1:0]   i_mmu_paddr;
    logic [EXCP_W-1:0] i_mmu_excp;
    logic              o_ic_req;
    logic [IDX_W-1:0]  o_ic_idx;
    logic [TAG_W-1:0]  o_ic_tag;
    logic              i_ic_hit;
    logic [LINE_W-1:0] i_ic_rdat;
    logic              o_mem_vld;
    logic              i_mem_rdy;
    logic [PA_W-1:0]   o_mem_paddr;
    logic              i_mem_rsp_vld;
    logic [LINE_W-1:0] i_mem_data;
    logic              o_ic_wren;
    logic [IDX_W-1:0]  o_ic_widx;
    logic [TAG_W-1:0]  o_ic_wtag;
    logic [LINE_W-1:0] o_ic_wdat;
    logic              i_inv_vld;
    logic [PA_W-1:0]   i_inv_paddr;
    logic              o_rsp_vld;
    logic              i_rsp_rdy;
    logic [LINE_W-1:0] o_rsp_data;
    logic [EXCP_W-1:0] o_rsp_excp;
    logic [ID_W-1:0]   o_rsp_id;
    logic              o_stall;

    modport master (
        input  i_flush, i_req_vld, i_req_pc, i_req_id, i_itlb_hit, i_itlb_ppn,
               i_mmu_rdy, i_mmu_rsp_vld, i_mmu_paddr, i_mmu_excp, i_ic_hit, i_ic_rdat,
               i_mem_rdy, i_mem_rsp_vld, i_mem_data, i_inv_vld, i_inv_paddr, i_rsp_rdy,
        output o_req_rdy, o_itlb_req, o_itlb_vaddr, o_mmu_vld, o_mmu_vaddr, o_ic_req,
               o_ic_idx, o_ic_tag, o_mem_vld, o_mem_paddr, o_ic_wren, o_ic_widx,
               o_ic_wtag, o_ic_wdat, o_rsp_vld, o_rsp_data, o_rsp_excp, o_rsp_id, o_stall
    );

    modport slave (
        output i_flush, i_req_vld, i_req_pc, i_req_id, i_itlb_hit, i_itlb_ppn,
               i_mmu_rdy, i_mmu_rsp_vld, i_mmu_paddr, i_mmu_excp, i_ic_hit, i_ic_rdat,
               i_mem_rdy, i_mem_rsp_vld, i_mem_data, i_inv_vld, i_inv_paddr, i_rsp_rdy,
        input  o_req_rdy, o_itlb_req, o_itlb_vaddr, o_mmu_vld, o_mmu_vaddr, o_ic_req,
               o_ic_idx, o_ic_tag, o_mem_vld, o_mem_paddr, o_ic_wren, o_ic_widx,
               o_ic_wtag, o_ic_wdat, o_rsp_vld, o_rsp_data, o_rsp_excp, o_rsp_id, o_stall
    );

endinterface

// File: rtl/gnrl_dffr.sv
// Generic resettable D flop bank: clears asynchronously to zero, loads dnxt every cycle.
module gnrl_dffr #(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) qout <= '0;
        else        qout <= dnxt;
    end

endmodule

// File: rtl/icache_refill_ctrl_module_fsm.sv
// Fetch-lifetime state machine: next-state decision, state register and the
// one-cycle array-write strobe raised when a refill line lands.
module icache_refill_fsm_module
    import icache_refill_ctrl_module_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_flush,
    input  logic   i_req_vld,
    input  logic   i_itlb_hit,
    input  logic   i_mmu_rdy,
    input  logic   i_mmu_rsp_vld,
    input  logic   i_mmu_fault,
    input  logic   i_ic_hit,
    input  logic   i_mem_rdy,
    input  logic   i_mem_rsp_vld,
    input  logic   i_fill_block,
    input  logic   i_rsp_rdy,
    output state_e o_state,
    output logic   o_ic_wren
);

    state_e r_state;
    logic   r_ic_wren;

    // NOTE: non-blocking assignments make every branch below see pre-edge state, never a half-updated one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ic_wren <= 1'b0;
        end else begin
            r_ic_wren <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_req_vld && !i_flush) r_state <= i_itlb_hit ? ST_PROBE : ST_MMU_REQ;
                end
                ST_MMU_REQ: begin
                    if (i_flush)        r_state <= ST_IDLE;
                    else if (i_mmu_rdy) r_state <= ST_MMU_WAIT;
                end
                ST_MMU_WAIT: begin
                    if (i_mmu_rsp_vld) begin
                        if (i_flush)          r_state <= ST_IDLE;
                        else if (i_mmu_fault) r_state <= ST_RESP;
                        else                  r_state <= ST_PROBE;
                    end else if (i_flush) begin
                        r_state <= ST_DRAIN_MMU;
                    end
                end
                ST_DRAIN_MMU: begin
                    if (i_mmu_rsp_vld) r_state <= ST_IDLE;
                end
                ST_PROBE: begin
                    if (i_flush)       r_state <= ST_IDLE;
                    else if (i_ic_hit) r_state <= ST_RESP;
                    else               r_state <= ST_MEM_REQ;
                end
                ST_MEM_REQ: begin
                    if (i_flush)        r_state <= ST_IDLE;
                    else if (i_mem_rdy) r_state <= ST_MEM_WAIT;
                end
                ST_MEM_WAIT: begin
                    if (i_mem_rsp_vld) begin
                        r_state   <= i_flush ? ST_IDLE : ST_RESP;
                        r_ic_wren <= !i_fill_block;
                    end else if (i_flush) begin
                        r_state <= ST_DRAIN_MEM;
                    end
                end
                ST_DRAIN_MEM: begin
                    // A flushed refill still lands in the array so the memory traffic is not wasted.
                    if (i_mem_rsp_vld) begin
                        r_state   <= ST_IDLE;
                        r_ic_wren <= !i_fill_block;
                    end
                end
                ST_RESP: begin
                    if (i_flush || i_rsp_rdy) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_state   = r_state;
    assign o_ic_wren = r_ic_wren;

endmodule

// File: rtl/icache_refill_ctrl_module.sv
// Instruction-fetch front end: walks one outstanding fetch through ITLB, MMU walk,
// icache probe and memory refill, with flush draining and invalidate snooping.
module icache_refill_ctrl_module
    import icache_refill_ctrl_module_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int PA_W   = PA_W_DEF,
    parameter int LINE_W = LINE_W_DEF,
    parameter int SETS   = SETS_DEF,
    parameter int ID_W   = ID_W_DEF,
    parameter int EXCP_W = EXCP_W_DEF
) (
    input logic                   clk,
    input logic                   rst_n,
    icache_refill_ctrl_module_if.master bus
);

    localparam int OFS_W = ofs_w(LINE_W);
    localparam int IDX_W = idx_w(SETS);
    localparam int TAG_W = tag_w(PA_W, LINE_W, SETS);
    localparam int LN_W  = PA_W - OFS_W;

    state_e w_state;
    logic   w_ic_wren;
    logic   w_accept;
    logic   w_mmu_fault;
    logic   w_snoop_hit;
    logic   w_fill_block;
    logic   w_unused_ok;

    logic [PC_W-1:0]   r_pc,     w_pc_nxt;
    logic [ID_W-1:0]   r_id,     w_id_nxt;
    logic [PA_W-1:0]   r_paddr,  w_paddr_nxt;
    logic [EXCP_W-1:0] r_excp,   w_excp_nxt;
    logic [LINE_W-1:0] r_line,   w_line_nxt;
    logic              r_nofill, w_nofill_nxt;

    assign w_accept    = (w_state == ST_IDLE) && bus.i_req_vld && !bus.i_flush;
    assign w_mmu_fault = bus.i_mmu_excp != EXCP_W'(EXCP_NONE);
    assign w_snoop_hit = bus.i_inv_vld
                       && (w_state inside {ST_MEM_REQ, ST_MEM_WAIT, ST_DRAIN_MEM})
                       && (bus.i_inv_paddr[PA_W-1:OFS_W] == r_paddr[PA_W-1:OFS_W]);
    // A snoop landing with the refill data must block that very write.
    assign w_fill_block = r_nofill || w_snoop_hit;

    // Page offset of the walk result and line offset of the snoop address carry no information here.
    assign w_unused_ok = &{1'b0, bus.i_mmu_paddr[PAGE_OFS_W-1:0], bus.i_inv_paddr[OFS_W-1:0]};

    icache_refill_fsm_module u_fsm (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_flush       (bus.i_flush),
        .i_req_vld     (bus.i_req_vld),
        .i_itlb_hit    (bus.i_itlb_hit),
        .i_mmu_rdy     (bus.i_mmu_rdy),
        .i_mmu_rsp_vld (bus.i_mmu_rsp_vld),
        .i_mmu_fault   (w_mmu_fault),
        .i_ic_hit      (bus.i_ic_hit),
        .i_mem_rdy     (bus.i_mem_rdy),
        .i_mem_rsp_vld (bus.i_mem_rsp_vld),
        .i_fill_block  (w_fill_block),
        .i_rsp_rdy     (bus.i_rsp_rdy),
        .o_state       (w_state),
        .o_ic_wren     (w_ic_wren)
    );

    // NOTE: each next-value defaults to its current value first, so no branch can leave one unassigned and infer a latch.
    always_comb begin
        w_pc_nxt     = r_pc;
        w_id_nxt     = r_id;
        w_paddr_nxt  = r_paddr;
        w_excp_nxt   = r_excp;
        w_line_nxt   = r_line;
        w_nofill_nxt = r_nofill;

        if (w_accept) begin
            w_pc_nxt     = bus.i_req_pc;
            w_id_nxt     = bus.i_req_id;
            w_excp_nxt   = '0;
            w_line_nxt   = '0;
            w_nofill_nxt = 1'b0;
            if (bus.i_itlb_hit) w_paddr_nxt = {bus.i_itlb_ppn, bus.i_req_pc[PAGE_OFS_W-1:0]};
        end

        if ((w_state == ST_MMU_WAIT) && bus.i_mmu_rsp_vld) begin
            w_excp_nxt = bus.i_mmu_excp;
            if (!w_mmu_fault) w_paddr_nxt = {bus.i_mmu_paddr[PA_W-1:PAGE_OFS_W], r_pc[PAGE_OFS_W-1:0]};
        end

        if ((w_state == ST_PROBE) && bus.i_ic_hit) w_line_nxt = bus.i_ic_rdat;

        if ((w_state inside {ST_MEM_WAIT, ST_DRAIN_MEM}) && bus.i_mem_rsp_vld) w_line_nxt = bus.i_mem_data;

        if (w_snoop_hit) w_nofill_nxt = 1'b1;
    end

    gnrl_dffr #(.DW(PC_W))   u_pc_dff     (.clk(clk), .rst_n(rst_n), .dnxt(w_pc_nxt),     .qout(r_pc));
    gnrl_dffr #(.DW(ID_W))   u_id_dff     (.clk(clk), .rst_n(rst_n), .dnxt(w_id_nxt),     .qout(r_id));
    gnrl_dffr #(.DW(PA_W))   u_paddr_dff  (.clk(clk), .rst_n(rst_n), .dnxt(w_paddr_nxt),  .qout(r_paddr));
    gnrl_dffr #(.DW(EXCP_W)) u_excp_dff   (.clk(clk), .rst_n(rst_n), .dnxt(w_excp_nxt),   .qout(r_excp));
    gnrl_dffr #(.DW(LINE_W)) u_line_dff   (.clk(clk), .rst_n(rst_n), .dnxt(w_line_nxt),   .qout(r_line));
    gnrl_dffr #(.DW(1))      u_nofill_dff (.clk(clk), .rst_n(rst_n), .dnxt(w_nofill_nxt), .qout(r_nofill));

    assign bus.o_req_rdy    = (w_state == ST_IDLE);
    assign bus.o_itlb_req   = w_accept;
    assign bus.o_itlb_vaddr = w_accept ? bus.i_req_pc : '0;

    // Request strobes fall in the flush cycle itself so no handshake completes on a dead fetch.
    assign bus.o_mmu_vld    = (w_state == ST_MMU_REQ) && !bus.i_flush;
    assign bus.o_mmu_vaddr  = r_pc;

    assign bus.o_ic_req     = (w_state == ST_PROBE);
    assign bus.o_ic_idx     = r_paddr[OFS_W +: IDX_W];
    assign bus.o_ic_tag     = r_paddr[PA_W-1 -: TAG_W];

    assign bus.o_mem_vld    = (w_state == ST_MEM_REQ) && !bus.i_flush;
    assign bus.o_mem_paddr  = {r_paddr[PA_W-1 -: LN_W], {OFS_W{1'b0}}};

    assign bus.o_ic_wren    = w_ic_wren;
    assign bus.o_ic_widx    = r_paddr[OFS_W +: IDX_W];
    assign bus.o_ic_wtag    = r_paddr[PA_W-1 -: TAG_W];
    assign bus.o_ic_wdat    = r_line;

    assign bus.o_rsp_vld    = (w_state == ST_RESP) && !bus.i_flush;
    assign bus.o_rsp_data   = r_line;
    assign bus.o_rsp_excp   = r_excp;
    assign bus.o_rsp_id     = r_id;

    assign bus.o_stall      = (w_state != ST_IDLE) && (w_state != ST_RESP);

endmodule

// File: tb/tb_icache_refill_ctrl_module.sv
// Directed bench for the icache refill controller: hand-computed expectations checked
// with immediate assertions at fixed points one time unit after each rising edge.
module tb_icache_refill_ctrl_module;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic [511:0] line_a, line_b, line_c, line_d, line_e;

    icache_refill_ctrl_module_if bus ();

    icache_refill_ctrl_module dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // ITLB hit at pc 0x4044 -> paddr 0x2_0000_1044, icache miss, memory accepts at once.
    task automatic miss_to_mem_wait(input logic [1:0] id);
        bus.i_req_vld  = 1'b1;
        bus.i_req_pc   = 39'h4044;
        bus.i_req_id   = id;
        bus.i_itlb_hit = 1'b1;
        bus.i_itlb_ppn = 22'h200001;
        tick();
        bus.i_req_vld  = 1'b0;
        bus.i_itlb_hit = 1'b0;
        bus.i_ic_hit   = 1'b0;
        tick();
        bus.i_mem_rdy  = 1'b1;
        tick();
        bus.i_mem_rdy  = 1'b0;
    endtask

    task automatic hit_to_resp(input logic [1:0] id, input logic [511:0] rdat);
        bus.i_req_vld  = 1'b1;
        bus.i_req_pc   = 39'h80001040;
        bus.i_req_id   = id;
        bus.i_itlb_hit = 1'b1;
        bus.i_itlb_ppn = 22'h12345;
        tick();
        bus.i_req_vld  = 1'b0;
        bus.i_itlb_hit = 1'b0;
        bus.i_ic_hit   = 1'b1;
        bus.i_ic_rdat  = rdat;
        tick();
        bus.i_ic_hit   = 1'b0;
        bus.i_ic_rdat  = '0;
    endtask

    initial begin
        line_a = {16{32'hA5A5_0001}};
        line_b = {16{32'hB0B0_0002}};
        line_c = {16{32'hC3C3_0003}};
        line_d = {16{32'hD4D4_0004}};
        line_e = {16{32'hE5E5_0005}};

        bus.i_flush = 0; bus.i_req_vld = 0; bus.i_req_pc = '0; bus.i_req_id = '0;
        bus.i_itlb_hit = 0; bus.i_itlb_ppn = '0; bus.i_mmu_rdy = 0; bus.i_mmu_rsp_vld = 0;
        bus.i_mmu_paddr = '0; bus.i_mmu_excp = '0; bus.i_ic_hit = 0; bus.i_ic_rdat = '0;
        bus.i_mem_rdy = 0; bus.i_mem_rsp_vld = 0; bus.i_mem_data = '0; bus.i_inv_vld = 0;
        bus.i_inv_paddr = '0; bus.i_rsp_rdy = 0;

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_rdy",  bus.o_req_rdy,  1'b1);
        check("rst_rsp_vld",  bus.o_rsp_vld,  1'b0);
        check("rst_stall",    bus.o_stall,    1'b0);
        check("rst_mem_vld",  bus.o_mem_vld,  1'b0);
        check("rst_mmu_vld",  bus.o_mmu_vld,  1'b0);
        check("rst_ic_wren",  bus.o_ic_wren,  1'b0);
        check("rst_rsp_data", bus.o_rsp_data, '0);
        rst_n = 1'b1;
        tick();

        // ITLB hit + icache hit: response two cycles after acceptance
        bus.i_req_vld = 1'b1; bus.i_req_pc = 39'h80001040; bus.i_req_id = 2'd2;
        bus.i_itlb_hit = 1'b1; bus.i_itlb_ppn = 22'h12345;
        settle();
        check("t1_itlb_req",   bus.o_itlb_req,   1'b1);
        check("t1_itlb_vaddr", bus.o_itlb_vaddr, 39'h80001040);
        tick();
        bus.i_req_vld = 1'b0; bus.i_itlb_hit = 1'b0; bus.i_ic_hit = 1'b1; bus.i_ic_rdat = line_a;
        settle();
        check("t1_ic_req", bus.o_ic_req, 1'b1);
        check("t1_ic_idx", bus.o_ic_idx, 8'h41);
        check("t1_ic_tag", bus.o_ic_tag, 20'h048D1);
        check("t1_no_rsp", bus.o_rsp_vld, 1'b0);
        tick();
        bus.i_ic_hit = 1'b0; bus.i_ic_rdat = '0;
        settle();
        check("t1_rsp_vld",  bus.o_rsp_vld,  1'b1);
        check("t1_rsp_data", bus.o_rsp_data, line_a);
        check("t1_rsp_excp", bus.o_rsp_excp, 3'd0);
        check("t1_rsp_id",   bus.o_rsp_id,   2'd2);
        check("t1_stall",    bus.o_stall,    1'b0);
        check("t1_req_rdy",  bus.o_req_rdy,  1'b0);
        bus.i_rsp_rdy = 1'b1;
        tick();
        bus.i_rsp_rdy = 1'b0;
        settle();
        check("t1_idle_rdy", bus.o_req_rdy, 1'b1);
        check("t1_rsp_done", bus.o_rsp_vld, 1'b0);

        // A flush in IDLE blocks the request
        bus.i_req_vld = 1'b1; bus.i_flush = 1'b1;
        settle();
        check("fl_idle_itlb", bus.o_itlb_req, 1'b0);
        tick();
        bus.i_req_vld = 1'b0; bus.i_flush = 1'b0;
        settle();
        check("fl_idle_rdy",   bus.o_req_rdy, 1'b1);
        check("fl_idle_stall", bus.o_stall,   1'b0);

        // ITLB hit, icache miss, memory accept delayed three cycles
        bus.i_req_vld = 1'b1; bus.i_req_pc = 39'h4044; bus.i_req_id = 2'd1;
        bus.i_itlb_hit = 1'b1; bus.i_itlb_ppn = 22'h200001;
        tick();
        bus.i_req_vld = 1'b0; bus.i_itlb_hit = 1'b0; bus.i_ic_hit = 1'b0;
        settle();
        check("t2_ic_req", bus.o_ic_req, 1'b1);
        tick();
        settle();
        check("t2_mem_vld",   bus.o_mem_vld,   1'b1);
        check("t2_mem_paddr", bus.o_mem_paddr, 34'h2_0000_1040);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_mem_vld_held", bus.o_mem_vld, 1'b1);
        end
        bus.i_mem_rdy = 1'b1;
        tick();
        bus.i_mem_rdy = 1'b0;
        settle();
        check("t2_mem_vld_drop", bus.o_mem_vld, 1'b0);
        check("t2_wait_stall",   bus.o_stall,   1'b1);
        bus.i_inv_vld = 1'b1; bus.i_inv_paddr = 34'h2_0000_1080;
        tick();
        bus.i_inv_vld = 1'b0; bus.i_mem_rsp_vld = 1'b1; bus.i_mem_data = line_b;
        tick();
        bus.i_mem_rsp_vld = 1'b0; bus.i_mem_data = '0;
        settle();
        check("t2_wren",     bus.o_ic_wren,  1'b1);
        check("t2_widx",     bus.o_ic_widx,  8'h41);
        check("t2_wtag",     bus.o_ic_wtag,  20'h80000);
        check("t2_wdat",     bus.o_ic_wdat,  line_b);
        check("t2_rsp_vld",  bus.o_rsp_vld,  1'b1);
        check("t2_rsp_data", bus.o_rsp_data, line_b);
        check("t2_rsp_id",   bus.o_rsp_id,   2'd1);
        tick();
        check("t2_wren_pulse", bus.o_ic_wren, 1'b0);
        check("t2_rsp_hold",   bus.o_rsp_vld, 1'b1);
        bus.i_rsp_rdy = 1'b1;
        tick();
        bus.i_rsp_rdy = 1'b0;

        // ITLB miss, walk returns fault 5
        bus.i_req_vld = 1'b1; bus.i_req_pc = 39'h1_2345_6789; bus.i_req_id = 2'd3; bus.i_itlb_hit = 1'b0;
        settle();
        check("t3_itlb_req", bus.o_itlb_req, 1'b1);
        tick();
        bus.i_req_vld = 1'b0;
        settle();
        check("t3_mmu_vld",   bus.o_mmu_vld,   1'b1);
        check("t3_mmu_vaddr", bus.o_mmu_vaddr, 39'h1_2345_6789);
        check("t3_no_probe",  bus.o_ic_req,    1'b0);
        bus.i_mmu_rdy = 1'b1;
        tick();
        bus.i_mmu_rdy = 1'b0;
        settle();
        check("t3_mmu_vld_drop", bus.o_mmu_vld, 1'b0);
        bus.i_mmu_rsp_vld = 1'b1; bus.i_mmu_excp = 3'd5; bus.i_mmu_paddr = 34'h3_FFFF_F000;
        tick();
        bus.i_mmu_rsp_vld = 1'b0; bus.i_mmu_excp = 3'd0;
        settle();
        check("t3_rsp_vld",  bus.o_rsp_vld,  1'b1);
        check("t3_rsp_excp", bus.o_rsp_excp, 3'd5);
        check("t3_rsp_data", bus.o_rsp_data, '0);
        check("t3_rsp_id",   bus.o_rsp_id,   2'd3);
        check("t3_no_probe2", bus.o_ic_req,  1'b0);
        check("t3_no_mem",   bus.o_mem_vld,  1'b0);
        bus.i_rsp_rdy = 1'b1;
        tick();
        bus.i_rsp_rdy = 1'b0;

        // Flush in MEM_WAIT, refill data four cycles later
        miss_to_mem_wait(2'd0);
        bus.i_flush = 1'b1;
        settle();
        check("t4_flush_stall", bus.o_stall, 1'b1);
        tick();
        bus.i_flush = 1'b0;
        settle();
        check("t4_drain_rdy1", bus.o_req_rdy, 1'b0);
        check("t4_drain_rsp",  bus.o_rsp_vld, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("t4_drain_rdy", bus.o_req_rdy, 1'b0);
        end
        tick();
        bus.i_mem_rsp_vld = 1'b1; bus.i_mem_data = line_c;
        settle();
        check("t4_rsp_cycle_rdy", bus.o_req_rdy, 1'b0);
        tick();
        bus.i_mem_rsp_vld = 1'b0; bus.i_mem_data = '0;
        settle();
        check("t4_after_rdy", bus.o_req_rdy, 1'b1);
        check("t4_wren",      bus.o_ic_wren, 1'b1);
        check("t4_wdat",      bus.o_ic_wdat, line_c);
        check("t4_no_rsp",    bus.o_rsp_vld, 1'b0);
        tick();
        check("t4_wren_pulse", bus.o_ic_wren, 1'b0);
        check("t4_no_rsp2",    bus.o_rsp_vld, 1'b0);

        // Matching invalidate during MEM_WAIT suppresses the array write
        miss_to_mem_wait(2'd2);
        bus.i_inv_vld = 1'b1; bus.i_inv_paddr = 34'h2_0000_1078;
        tick();
        bus.i_inv_vld = 1'b0; bus.i_mem_rsp_vld = 1'b1; bus.i_mem_data = line_d;
        tick();
        bus.i_mem_rsp_vld = 1'b0; bus.i_mem_data = '0;
        settle();
        check("t5_no_wren",  bus.o_ic_wren,  1'b0);
        check("t5_rsp_vld",  bus.o_rsp_vld,  1'b1);
        check("t5_rsp_data", bus.o_rsp_data, line_d);
        check("t5_rsp_id",   bus.o_rsp_id,   2'd2);
        bus.i_rsp_rdy = 1'b1;
        tick();
        bus.i_rsp_rdy = 1'b0;

        // Invalidate in the same cycle as the refill data
        miss_to_mem_wait(2'd1);
        bus.i_inv_vld = 1'b1; bus.i_inv_paddr = 34'h2_0000_1040;
        bus.i_mem_rsp_vld = 1'b1; bus.i_mem_data = line_e;
        tick();
        bus.i_inv_vld = 1'b0; bus.i_mem_rsp_vld = 1'b0; bus.i_mem_data = '0;
        settle();
        check("t5b_no_wren",  bus.o_ic_wren,  1'b0);
        check("t5b_rsp_data", bus.o_rsp_data, line_e);
        bus.i_rsp_rdy = 1'b1;
        tick();
        bus.i_rsp_rdy = 1'b0;

        // Response back-pressure: five cycles of rsp_rdy low
        hit_to_resp(2'd1, line_e);
        bus.i_req_id = 2'd3;
        for (int i = 0; i < 5; i++) begin
            settle();
            check("t6_rsp_vld",  bus.o_rsp_vld,  1'b1);
            check("t6_rsp_data", bus.o_rsp_data, line_e);
            check("t6_rsp_id",   bus.o_rsp_id,   2'd1);
            tick();
        end
        bus.i_rsp_rdy = 1'b1;
        tick();
        bus.i_rsp_rdy = 1'b0;
        settle();
        check("t6_idle_rdy", bus.o_req_rdy, 1'b1);

        // Flush during RESP drops the response
        hit_to_resp(2'd0, line_a);
        bus.i_flush = 1'b1;
        tick();
        bus.i_flush = 1'b0;
        settle();
        check("fl_resp_rsp", bus.o_rsp_vld, 1'b0);
        check("fl_resp_rdy", bus.o_req_rdy, 1'b1);

        // Flush in MMU_WAIT drains the walk
        bus.i_req_vld = 1'b1; bus.i_req_pc = 39'h5000; bus.i_itlb_hit = 1'b0;
        tick();
        bus.i_req_vld = 1'b0; bus.i_mmu_rdy = 1'b1;
        tick();
        bus.i_mmu_rdy = 1'b0; bus.i_flush = 1'b1;
        tick();
        bus.i_flush = 1'b0;
        settle();
        check("fl_mmu_drain_rdy",   bus.o_req_rdy, 1'b0);
        check("fl_mmu_drain_stall", bus.o_stall,   1'b1);
        bus.i_mmu_rsp_vld = 1'b1;
        tick();
        bus.i_mmu_rsp_vld = 1'b0;
        settle();
        check("fl_mmu_done_rdy", bus.o_req_rdy, 1'b1);
        check("fl_mmu_no_rsp",   bus.o_rsp_vld, 1'b0);

        // Flush coinciding with the walk response returns straight to IDLE
        bus.i_req_vld = 1'b1; bus.i_req_pc = 39'h6000; bus.i_itlb_hit = 1'b0;
        tick();
        bus.i_req_vld = 1'b0; bus.i_mmu_rdy = 1'b1;
        tick();
        bus.i_mmu_rdy = 1'b0; bus.i_flush = 1'b1; bus.i_mmu_rsp_vld = 1'b1;
        tick();
        bus.i_flush = 1'b0; bus.i_mmu_rsp_vld = 1'b0;
        settle();
        check("fl_mmu_same_rdy",   bus.o_req_rdy, 1'b1);
        check("fl_mmu_same_stall", bus.o_stall,   1'b0);

        // Reset pulse in the middle of MEM_WAIT
        miss_to_mem_wait(2'd3);
        settle();
        check("rm_pre_stall", bus.o_stall, 1'b1);
        rst_n = 1'b0;
        settle();
        check("rm_req_rdy",   bus.o_req_rdy,   1'b1);
        check("rm_stall",     bus.o_stall,     1'b0);
        check("rm_mem_vld",   bus.o_mem_vld,   1'b0);
        check("rm_rsp_vld",   bus.o_rsp_vld,   1'b0);
        check("rm_rsp_id",    bus.o_rsp_id,    2'd0);
        check("rm_mem_paddr", bus.o_mem_paddr, '0);
        check("rm_ic_idx",    bus.o_ic_idx,    '0);
        check("rm_ic_wren",   bus.o_ic_wren,   1'b0);
        tick();
        rst_n = 1'b1;
        bus.i_mem_rsp_vld = 1'b1; bus.i_mem_data = line_a;
        tick();
        bus.i_mem_rsp_vld = 1'b0; bus.i_mem_data = '0;
        settle();
        check("rm_late_wren", bus.o_ic_wren, 1'b0);
        check("rm_late_rsp",  bus.o_rsp_vld, 1'b0);
        check("rm_late_rdy",  bus.o_req_rdy, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
